// File: rtl/uart_wb_ctrl.sv
// uart_wb_ctrl: Wishbone register front-end for a UART tx/rx core pair.
// Holds TX/RX FIFOs, sticky error flags, a control register with IRQ
// enables and flush strobes, and paces TX handoffs with an idle gap.
module uart_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned TX_GAP    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_valid,
  input  logic [31:0]       i_wb_adr,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_dat,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_frame_err,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_ready,
  input  logic              i_tx_busy,
  output logic              o_irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  typedef enum logic [1:0] {
    REG_RX_DATA = 2'd0,
    REG_TX_DATA = 2'd1,
    REG_STAT    = 2'd2,
    REG_CTRL    = 2'd3
  } reg_off_e;

  // Bus decode
  logic     hit, accept, wr, rd;
  reg_off_e off;

  assign hit    = (i_wb_adr[31:4] == BASE_ADDR[31:4]);
  assign off    = reg_off_e'(i_wb_adr[3:2]);
  assign accept = hit && i_wb_valid && !o_wb_ack;
  assign wr     = accept && i_wb_we;
  assign rd     = accept && !i_wb_we;

  // Control register and strobes
  logic [2:0] ctrl;
  logic       ctrl_we, tx_flush, rx_flush;

  assign ctrl_we  = wr && (off == REG_CTRL) && i_wb_sel[0];
  assign tx_flush = ctrl_we && i_wb_dat[3];
  assign rx_flush = ctrl_we && i_wb_dat[4];

  // RX FIFO state
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wp, rx_rp;
  logic [RX_AW:0]    rx_cnt;
  logic              rx_empty, rx_full, rx_push, rx_pop;

  // TX FIFO state
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wp, tx_rp;
  logic [TX_AW:0]    tx_cnt;
  logic              tx_empty, tx_full, tx_wr_hit, tx_push, tx_pop;
  logic [GAP_W-1:0]  gap_cnt;

  // Sticky flags: {tx_ovf, frame_err, overrun}
  logic [2:0] sticky, sticky_set, sticky_clr;
  logic [31:0] stat, rdata;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (TX_AW+1)'(TX_DEPTH));

  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign rx_pop  = rd && (off == REG_RX_DATA) && !rx_empty;
  assign rx_push = i_rx_valid && !i_frame_err && (!rx_full || rx_pop) && !rx_flush;

  assign tx_wr_hit = wr && (off == REG_TX_DATA) && i_wb_sel[0];
  assign tx_push   = tx_wr_hit && !tx_full;
  assign tx_pop    = o_tx_valid && i_tx_ready;

  assign o_tx_valid = !tx_empty && (gap_cnt == '0);
  assign o_tx_data  = tx_empty ? '0 : tx_mem[tx_rp];

  // Flush suppresses every RX-side flag event in its cycle.
  assign sticky_set = {tx_wr_hit && tx_full,
                       i_rx_valid && i_frame_err && !rx_flush,
                       i_rx_valid && !i_frame_err && rx_full && !rx_pop && !rx_flush};
  assign sticky_clr = (wr && (off == REG_STAT)) ? i_wb_dat[6:4] : '0;

  assign stat = {8'h00, 8'(tx_cnt), 8'(rx_cnt), i_tx_busy, sticky,
                 tx_full, tx_empty, rx_full, rx_empty};

  // Read mux, sampled into o_wb_dat at the acceptance edge
  always_comb begin
    rdata = '0;
    case (off)
      REG_RX_DATA: begin
        if (!rx_empty) begin
          rdata[31]         = 1'b1;
          rdata[DATA_W-1:0] = rx_mem[rx_rp];
        end
      end
      REG_STAT: rdata = stat;
      REG_CTRL: rdata[2:0] = ctrl;
      default:  rdata = '0;
    endcase
  end

  // Bus response: one-cycle ack with registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= accept;
      o_wb_dat <= rd ? rdata : '0;
    end
  end

  // Control register; flush bits are strobes and never stored
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (ctrl_we) begin
      ctrl <= i_wb_dat[2:0];
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= i_rx_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RX_AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RX_AW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= i_wb_dat[DATA_W-1:0];
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TX_AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TX_AW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // Inter-byte gap counter: reload on handoff, count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (tx_pop) begin
      gap_cnt <= GAP_W'(TX_GAP);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Sticky error flags; a set event overrides a coincident clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty) || (ctrl[2] && (|sticky));
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_wb_adr[1:0], i_wb_sel[3:1], i_wb_dat[31:7]};

endmodule
